// File: rtl/score_pkg.sv
// Shared types and helpers for the score tracker: FSM state encoding,
// BCD digit type and a packed-BCD magnitude compare.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    COMMIT = 2'd2,
    OVER   = 2'd3
  } score_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  localparam int BCD_CMP_W = 32;

  // Valid packed BCD orders the same way as its raw binary value.
  function automatic logic bcd_gt(input logic [BCD_CMP_W-1:0] a,
                                  input logic [BCD_CMP_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/bcd_incrementer.sv
// Combinational +1 on a packed-BCD word with ripple carry through every
// digit; overflow flags an all-9s input (sum then wraps to zero).
module bcd_incrementer
  import score_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] sum,
  output logic                overflow
);

  logic       carry;
  bcd_digit_t digit;

  always_comb begin
    sum   = '0;
    carry = 1'b1;
    digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[4*i +: 4];
      if (carry) begin
        if (digit == BCD_MAX_DIGIT) begin
          sum[4*i +: 4] = 4'd0;
        end else begin
          sum[4*i +: 4] = digit + 4'd1;
          carry         = 1'b0;
        end
      end else begin
        sum[4*i +: 4] = digit;
      end
    end
    overflow = carry;
  end

endmodule

// File: rtl/score_tracker.sv
// Per-frame scroll-to-score accumulator with high-score tracking and HEX
// display select. High-score logic is built only when SCORE_HIGH_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a frame tick, a held frame, or game over
// ACCUM  | one BCD increment per cycle until count drains
// COMMIT | single cycle: compare score against high score
// OVER   | score frozen until game_over drops, then cleared
module score_tracker
  import score_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                refresh_en,
  input  logic [7:0]          displacement,
  input  logic                game_over,
  input  logic                show_high,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic                busy,
  output logic                saturated,
  output logic                new_high
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = 9 - SCALE_SHIFT;

  score_state_t           state;
  logic [2:0]             fsync;
  logic                   frame_tick;
  logic [W-1:0]           score_inc;
  logic                   inc_ovf;
  logic [SCALE_SHIFT-1:0] frac;
  logic [CNT_W-1:0]       count;
  logic                   pending;
  logic                   hold_en;
  logic [7:0]             hold_disp;
  logic                   go_prev;
  logic                   go_rise;
  logic                   over_req;
  logic [7:0]             src_disp;
  logic [8:0]             total;
  logic [CNT_W-1:0]       new_count;

  // frame_clk is asynchronous: two sync flops plus one history flop
  always_ff @(posedge Clk) begin
    if (Reset) fsync <= '0;
    else       fsync <= {fsync[1:0], frame_clk};
  end

  assign frame_tick = fsync[1] & ~fsync[2];
  assign go_rise    = game_over & ~go_prev;
  assign src_disp   = pending ? hold_disp : displacement;
  assign total      = 9'(src_disp) + 9'(frac);
  assign new_count  = total[8:SCALE_SHIFT];

  bcd_incrementer #(.DIGITS(DIGITS)) u_inc (
    .value    (score_bcd),
    .sum      (score_inc),
    .overflow (inc_ovf)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      score_bcd <= '0;
      frac      <= '0;
      count     <= '0;
      pending   <= 1'b0;
      hold_en   <= 1'b0;
      hold_disp <= '0;
      go_prev   <= 1'b0;
      over_req  <= 1'b0;
      busy      <= 1'b0;
      saturated <= 1'b0;
`ifdef SCORE_HIGH_EN
      high_bcd  <= '0;
      new_high  <= 1'b0;
`endif
    end else begin
      go_prev <= game_over;
`ifdef SCORE_HIGH_EN
      new_high <= 1'b0;
`endif
      if (go_rise) over_req <= 1'b1;

      case (state)
        IDLE: begin
          if (pending || (!(over_req || go_rise) && frame_tick && refresh_en)) begin
            // A held frame is drained before any pending game-over commit
            pending <= 1'b0;
            if (!pending || hold_en) begin
              frac  <= total[SCALE_SHIFT-1:0];
              count <= new_count;
              if (new_count != '0) begin
                state <= ACCUM;
                busy  <= 1'b1;
              end
            end
          end else if (over_req || go_rise) begin
            over_req <= 1'b0;
            state    <= COMMIT;
          end
        end

        ACCUM: begin
          if (frame_tick && !pending) begin
            pending   <= 1'b1;
            hold_en   <= refresh_en;
            hold_disp <= displacement;
          end
          if (inc_ovf) saturated <= 1'b1;
          else         score_bcd <= score_inc;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        COMMIT: begin
`ifdef SCORE_HIGH_EN
          if (bcd_gt(BCD_CMP_W'(score_bcd), BCD_CMP_W'(high_bcd))) begin
            high_bcd <= score_bcd;
            new_high <= 1'b1;
          end
`endif
          state <= OVER;
        end

        OVER: begin
          if (!game_over) begin
            score_bcd <= '0;
            frac      <= '0;
            pending   <= 1'b0;
            saturated <= 1'b0;
            over_req  <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORE_HIGH_EN
  always_ff @(posedge Clk) begin
    if (Reset) disp_bcd <= '0;
    else       disp_bcd <= show_high ? high_bcd : score_bcd;
  end
`else
  logic unused_show_high;
  assign unused_show_high = show_high;
  assign high_bcd         = '0;
  assign new_high         = 1'b0;

  always_ff @(posedge Clk) begin
    if (Reset) disp_bcd <= '0;
    else       disp_bcd <= score_bcd;
  end
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: a 6-digit instance and a 3-digit instance share
// stimulus; a decimal integer model predicts score, remainder and saturation.
module tb_score_tracker;

  logic        Clk          = 1'b0;
  logic        Reset        = 1'b1;
  logic        frame_clk    = 1'b0;
  logic        refresh_en   = 1'b0;
  logic [7:0]  displacement = 8'd0;
  logic        game_over    = 1'b0;
  logic        show_high    = 1'b0;

  logic [23:0] score_bcd, high_bcd, disp_bcd;
  logic        busy, saturated, new_high;
  logic [11:0] s_score, s_high, s_disp;
  logic        s_busy, s_sat, s_new_high;

  int vectors = 0;
  int errors  = 0;
  int bcnt = 0, sbcnt = 0, nhcnt = 0;

  int m_score = 0, m_ss = 0, m_frac = 0, m_high = 0, m_cnt = 0;
  bit m_sat = 1'b0;

  score_tracker dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .refresh_en(refresh_en),
    .displacement(displacement), .game_over(game_over), .show_high(show_high),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .disp_bcd(disp_bcd),
    .busy(busy), .saturated(saturated), .new_high(new_high)
  );

  score_tracker #(.DIGITS(3), .SCALE_SHIFT(2)) dut_s (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .refresh_en(refresh_en),
    .displacement(displacement), .game_over(game_over), .show_high(show_high),
    .score_bcd(s_score), .high_bcd(s_high), .disp_bcd(s_disp),
    .busy(s_busy), .saturated(s_sat), .new_high(s_new_high)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (busy)     bcnt++;
    if (s_busy)   sbcnt++;
    if (new_high) nhcnt++;
  end

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input bit en, input int disp);
    int t;
    m_cnt = 0;
    if (en) begin
      t      = m_frac + disp;
      m_cnt  = t / 4;
      m_frac = t % 4;
      m_score = (m_score + m_cnt > 999999) ? 999999 : m_score + m_cnt;
      if (m_ss + m_cnt > 999) begin
        m_ss  = 999;
        m_sat = 1'b1;
      end else begin
        m_ss = m_ss + m_cnt;
      end
    end
  endtask

  task automatic drive_edge(input bit en, input int disp);
    @(posedge Clk); #1;
    refresh_en   = en;
    displacement = 8'(disp);
    frame_clk    = 1'b1;
    repeat (4) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 600 && quiet < 3; i++) begin
      @(negedge Clk);
      quiet = (busy || s_busy) ? 0 : quiet + 1;
    end
    chk("idle_timeout", quiet, 3);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_score"},  score_bcd, to_bcd(m_score));
    chk({tag, "_score_s"}, s_score, to_bcd(m_ss));
    chk({tag, "_sat_s"},  s_sat, m_sat);
    chk({tag, "_sat"},    saturated, 0);
    chk({tag, "_disp"},   disp_bcd, to_bcd(m_score));
  endtask

  task automatic frame(input bit en, input int disp);
    int b0, sb0;
    b0  = bcnt;
    sb0 = sbcnt;
    drive_edge(en, disp);
    model_frame(en, disp);
    wait_idle();
    check_state("frame");
    chk("busy_cycles", bcnt - b0, m_cnt);
    chk("busy_cycles_s", sbcnt - sb0, m_cnt);
  endtask

  task automatic reach(input int target);
    int c;
    for (int k = 0; k < 40 && m_score < target; k++) begin
      c = (target - m_score > 63) ? 63 : target - m_score;
      frame(1'b1, 4 * c - m_frac);
    end
  endtask

  task automatic go_end();
    int nh0, b0, exp_nh;
    nh0 = nhcnt;
    @(posedge Clk); #1 game_over = 1'b1;
    wait_idle();
    repeat (4) @(negedge Clk);
    exp_nh = 0;
`ifdef SCORE_HIGH_EN
    if (m_score > m_high) begin
      m_high = m_score;
      exp_nh = 1;
    end
`endif
    chk("high", high_bcd, to_bcd(m_high));
    chk("new_high_pulses", nhcnt - nh0, exp_nh);
    chk("frozen_score", score_bcd, to_bcd(m_score));
    b0 = bcnt;
    drive_edge(1'b1, 100);
    repeat (4) @(negedge Clk);
    chk("over_ignores_frame", score_bcd, to_bcd(m_score));
    chk("over_no_busy", bcnt - b0, 0);
    @(posedge Clk); #1 show_high = 1'b1;
    repeat (2) @(negedge Clk);
`ifdef SCORE_HIGH_EN
    chk("disp_high", disp_bcd, to_bcd(m_high));
`else
    chk("disp_high", disp_bcd, to_bcd(m_score));
`endif
    @(posedge Clk); #1 show_high = 1'b0;
    game_over = 1'b0;
    repeat (3) @(negedge Clk);
    m_score = 0;
    m_ss    = 0;
    m_frac  = 0;
    m_sat   = 1'b0;
    chk("cleared_score", score_bcd, 0);
    chk("cleared_score_s", s_score, 0);
    chk("cleared_sat_s", s_sat, 0);
    chk("high_kept", high_bcd, to_bcd(m_high));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, cA, cB, en, d;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_score", score_bcd, 0);
    chk("rst_high", high_bcd, 0);
    chk("rst_disp", disp_bcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", saturated, 0);
    chk("rst_new_high", new_high, 0);

    // Three 8-pixel frames: two points each, no remainder
    for (int i = 0; i < 3; i++) frame(1'b1, 8);

    // Remainder carried across frames, then a zero and a disabled frame
    frame(1'b1, 3);
    frame(1'b1, 3);
    frame(1'b1, 3);
    frame(1'b1, 3);
    frame(1'b1, 0);
    frame(1'b0, 200);

    for (int i = 0; i < 10; i++) begin
      en = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 63);
      frame(en[0], d);
    end

    // Second frame lands mid-ACCUM and is held; third is dropped
    b0 = bcnt;
    drive_edge(1'b1, 200);
    model_frame(1'b1, 200);
    cA = m_cnt;
    drive_edge(1'b1, 100);
    model_frame(1'b1, 100);
    cB = m_cnt;
    drive_edge(1'b1, 252);
    wait_idle();
    check_state("pending");
    chk("pending_busy", bcnt - b0, cA + cB);

    // 998 -> 1008 ripples through three digits; 3-digit copy saturates
    reach(998);
    check_state("at998");
    frame(1'b1, 40);
    frame(1'b1, 2);

    go_end();
    frame(1'b1, 3);

    reach(120);
    go_end();

    // game_over raised while the last frame is still accumulating
    reach(1040);
    drive_edge(1'b1, 252 - m_frac);
    model_frame(1'b1, 252 - m_frac);
    #1 game_over = 1'b1;
    go_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
